// File: rtl/even_updown_checker.sv
// even_updown_checker: checks a 4-bit even up/down counter (+2 when y=0, -2 when y=1, mod 16).
// It reports lock status, a pulse for each bad transition and a saturating count of bad transitions.
`default_nettype none

// ============================================================================
// Module      : even_updown_checker
// Description : Transition checker with ACQUIRE/LOCKED tracking and error count
// Revision    : 1.0 - initial release
// ============================================================================
module even_updown_checker #(
    parameter int LOCK_COUNT = 2,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       q_in,
    input  logic             y_in,
    input  logic             clear_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       expected,
    output logic             dir_seen
);

    localparam logic [2:0] c_LOCK_CNT = 3'(LOCK_COUNT);
    localparam logic [2:0] c_LOSS_CNT = 3'(LOSS_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       prev_q_q, prev_q_d;
    logic             prev_y_q, prev_y_d;
    logic [2:0]       match_cnt_q, match_cnt_d;
    logic [2:0]       miss_cnt_q, miss_cnt_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [3:0]       expected_q, expected_d;
    logic             dir_seen_q, dir_seen_d;

    logic [3:0]       w_prev_plus2;
    logic [3:0]       w_prev_minus2;
    logic [3:0]       w_pred;
    logic [3:0]       w_next_pred;
    logic             w_good;
    logic             w_count_err;
    logic [ERR_W-1:0] w_err_base;

    assign w_prev_plus2  = prev_q_q + 4'd2;
    assign w_prev_minus2 = prev_q_q - 4'd2;
    assign w_pred        = prev_y_q ? w_prev_minus2 : w_prev_plus2;
    assign w_next_pred   = y_in ? (q_in - 4'd2) : (q_in + 4'd2);
    assign w_good        = (q_in == w_pred) && !q_in[0];

    always_comb begin
        state_d     = state_q;
        prev_q_d    = prev_q_q;
        prev_y_d    = prev_y_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        expected_d  = expected_q;
        dir_seen_d  = dir_seen_q;
        w_count_err = 1'b0;

        if (state_q != IDLE) begin
            if (q_in == w_prev_plus2) begin
                dir_seen_d = 1'b0;
            end else if (q_in == w_prev_minus2) begin
                dir_seen_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                state_d = ACQUIRE;
            end
            ACQUIRE: begin
                if (w_good) begin
                    if (match_cnt_q + 3'd1 == c_LOCK_CNT) begin
                        state_d     = LOCKED;
                        locked_d    = 1'b1;
                        match_cnt_d = 3'd0;
                    end else begin
                        match_cnt_d = match_cnt_q + 3'd1;
                    end
                end else begin
                    match_cnt_d = 3'd0;
                end
            end
            LOCKED: begin
                if (w_good) begin
                    miss_cnt_d = 3'd0;
                end else begin
                    err_pulse_d = 1'b1;
                    w_count_err = 1'b1;
                    // The edge that drops lock is still reported as an error.
                    if (miss_cnt_q + 3'd1 == c_LOSS_CNT) begin
                        state_d    = ACQUIRE;
                        locked_d   = 1'b0;
                        miss_cnt_d = 3'd0;
                    end else begin
                        miss_cnt_d = miss_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Every edge, including the first capture, samples q/y and refreshes the prediction.
        prev_q_d   = q_in;
        prev_y_d   = y_in;
        expected_d = w_next_pred;

        // Clear takes effect first; an error on the same edge then counts as one.
        w_err_base  = clear_err ? '0 : err_count_q;
        err_count_d = w_err_base;
        if (w_count_err && (w_err_base != {ERR_W{1'b1}})) begin
            err_count_d = w_err_base + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            prev_q_q    <= 4'd0;
            prev_y_q    <= 1'b0;
            match_cnt_q <= 3'd0;
            miss_cnt_q  <= 3'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            expected_q  <= 4'd0;
            dir_seen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q_q    <= prev_q_d;
            prev_y_q    <= prev_y_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            expected_q  <= expected_d;
            dir_seen_q  <= dir_seen_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign expected  = expected_q;
    assign dir_seen  = dir_seen_q;

endmodule

`default_nettype wire
